// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I definitions.
//   - base opcode constants (shared with the immediate decoder)
//   - fmt_e instruction format classes used by the encoder
//   - NOP_INSTR, the word stored in place of an unencodable request
//   - fmt_of(): maps an opcode/funct3 pair to its format class
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  // OP-IMM with funct3 001/101 is a shift: the upper immediate bits carry funct7.
  function automatic fmt_e fmt_of(input logic [6:0] op, input logic [2:0] f3);
    fmt_e f;
    case (op)
      OP_LUI, OP_AUIPC:   f = FMT_U;
      OP_JAL:             f = FMT_J;
      OP_JALR, OP_LOAD:   f = FMT_I;
      OP_IMM:             f = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
      OP_BRANCH:          f = FMT_B;
      OP_STORE:           f = FMT_S;
      OP_OP:              f = FMT_R;
      default:            f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, synchronous active-high reset.
//   push/wdata/full : write side (caller must not push when full)
//   pop/rdata/empty : read side; rdata reads as zero while empty
// A count register one bit wider than the pointers separates full from empty.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I field-to-word encoder.
//   in_*      : field-level request, valid/ready (in_ready = FIFO not full)
//   out_*     : FIFO head {out_err, out_instr}, valid/ready; zero when empty
//   enc_count : accepted requests, err_count : accepted requests with error
// Out-of-range immediates and unknown opcodes enqueue a NOP with out_err set.
module instr_encoder
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  fmt_e               fmt;
  logic [31:0]        word;
  logic               bad;
  logic signed [31:0] simm;
  logic               full, empty, accept;

  assign simm = in_imm;
  assign fmt  = fmt_of(in_opcode, in_funct3);

  always_comb begin
    word = NOP_INSTR;
    bad  = 1'b0;
    case (fmt)
      FMT_U: begin
        word = {in_imm[31:12], in_rd, in_opcode};
        bad  = (in_imm[11:0] != 12'h000);
      end
      FMT_J: begin
        word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        bad  = in_imm[0] || (simm < -32'sd1048576) || (simm > 32'sd1048574);
      end
      FMT_I: begin
        word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        bad  = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_SH: begin
        word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
        bad  = (in_imm[31:5] != 27'd0);
      end
      FMT_B: begin
        word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                in_imm[4:1], in_imm[11], in_opcode};
        bad  = in_imm[0] || (simm < -32'sd4096) || (simm > 32'sd4094);
      end
      FMT_S: begin
        word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        bad  = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_R: begin
        word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      default: bad = 1'b1;
    endcase
    if (bad) word = NOP_INSTR;
  end

  // No bypass: a pop in the same cycle does not free a slot for a full FIFO.
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;

  sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata ({bad, word}),
    .full  (full),
    .pop   (out_ready),
    .rdata ({out_err, out_instr}),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (accept) begin
      enc_count <= enc_count + CNT_W'(1);
      if (bad) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_instr;
  logic [15:0] enc_count, err_count;

  instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t        tbl[$];
  logic [32:0] sb[$];
  logic [32:0] cur_exp;
  int          checks = 0, errors = 0;
  int          exp_enc = 0, exp_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: sample at negedge, what is stable now happens at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_enc = 0;
      exp_err = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", {31'd0, out_err, out_instr}, 64'd0);
        else chk("scoreboard", {31'd0, out_err, out_instr}, {31'd0, sb.pop_front()});
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        exp_enc++;
        if (cur_exp[32]) exp_err++;
      end
    end
  end

  task automatic add(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                     input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm, input logic [31:0] exp, input logic err);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.exp = exp; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm; cur_exp = {v.err, v.exp};
  endtask

  // Present one request until accepted (bounded); optionally jitter out_ready.
  task automatic send(input vec_t v, input bit rnd);
    bit acc = 0;
    drive(v);
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 100 && sb.size() != 0; n++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    vec_t a, b, c;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; cur_exp = '0;

    //               op         rd  rs1 rs2 f3    f7        imm            expected      err
    add(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0); // addi x1,x0,-1
    add(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h123452B7, 1'b0); // lui
    add(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8,         32'h008000EF, 1'b0); // jal +8
    add(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0); // beq -4
    add(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,         32'h0020A423, 1'b0); // sw
    add(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      NOP,          1'b1); // addi 2048
    add(7'b1111111, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0,         NOP,          1'b1); // bad opcode
    add(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,         NOP,          1'b1); // beq odd
    add(7'b0010011, 5'd3, 5'd4, 5'd0, 3'd1, 7'h00, 32'd5,         32'h00521193, 1'b0); // slli 5
    add(7'b0010011, 5'd3, 5'd4, 5'd0, 3'd1, 7'h00, 32'd32,        NOP,          1'b1); // slli 32
    add(7'b0010011, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd31,        32'h41F25193, 1'b0); // srai 31
    add(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h002081B3, 1'b0); // add
    add(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,         32'h402081B3, 1'b0); // sub
    add(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, NOP,          1'b1); // lui low bits
    add(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000F_FFFE, 32'h7FFFF06F, 1'b0); // jal max
    add(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, NOP,          1'b1); // jal 2^20
    add(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0000, 32'h8000006F, 1'b0); // jal min
    add(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1,         NOP,          1'b1); // jal odd
    add(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,      32'h7E000FE3, 1'b0); // beq max
    add(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,      NOP,          1'b1); // beq 4096
    add(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 32'h80000063, 1'b0); // beq min
    add(7'b0000011, 5'd5, 5'd6, 5'd0, 3'd2, 7'h00, 32'hFFFF_F800, 32'h80032283, 1'b0); // lw -2048
    add(7'b0000011, 5'd5, 5'd6, 5'd0, 3'd2, 7'h00, 32'hFFFF_F7FF, NOP,          1'b1); // lw -2049
    add(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd2047,      32'h7E20AFA3, 1'b0); // sw 2047
    add(7'b0010111, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 32'hFFFFF517, 1'b0); // auipc
    add(7'b1100111, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF08067, 1'b0); // jalr -1

    repeat (3) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_out_err",   {63'd0, out_err},   64'd0);
    chk("rst_enc_count", {48'd0, enc_count}, 64'd0);
    chk("rst_err_count", {48'd0, err_count}, 64'd0);
    step();

    // First accept: visible at head the next cycle
    drive(tbl[0]);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_out_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_out_instr", {32'd0, out_instr}, 64'h0000_0000_FFF0_0093);
    chk("lat_out_err",   {63'd0, out_err},   64'd0);
    chk("lat_enc_count", {48'd0, enc_count}, 64'd1);
    drain();

    // Table pass 1: out_ready held high (steady push/pop at occupancy 1)
    out_ready = 1'b1;
    foreach (tbl[i]) send(tbl[i], 1'b0);
    drain();
    // Table pass 2: random backpressure, wraps the pointers many times
    foreach (tbl[i]) send(tbl[i], 1'b1);
    drain();
    chk("enc_count", {48'd0, enc_count}, 64'(exp_enc));
    chk("err_count", {48'd0, err_count}, 64'(exp_err));
    chk("err_count_value", {48'd0, err_count}, 64'(2 * 9));

    // Backpressure: two accepts fill the FIFO, third stalls
    a = tbl[1]; b = tbl[2]; c = tbl[3];
    out_ready = 1'b0;
    drive(a); step();
    drive(b); step();
    drive(c);
    @(negedge clk);
    chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_head", {32'd0, out_instr}, {32'd0, a.exp});
    step();
    @(negedge clk);
    chk("bp_stable_head", {32'd0, out_instr}, {32'd0, a.exp});
    chk("bp_still_full", {63'd0, in_ready}, 64'd0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_bypass", {63'd0, in_ready}, 64'd0);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
    chk("bp_head_after_pop", {32'd0, out_instr}, {32'd0, b.exp});
    step();
    in_valid = 1'b0;
    drain();

    // Reset while full with a request pending
    out_ready = 1'b0;
    drive(a); step();
    drive(b); step();
    drive(c);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("mrst_enc_count", {48'd0, enc_count}, 64'd0);
    chk("mrst_err_count", {48'd0, err_count}, 64'd0);
    chk("mrst_out_instr", {32'd0, out_instr}, 64'd0);
    step();
    @(negedge clk);
    chk("mrst_no_write", {63'd0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
